// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for serial_adder.
// SERIAL_ADDER_OVF_EN adds the signed-overflow result line.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
  logic             done;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;

  modport master (output start, sub, a, b, cin, input sum, cout, busy, done, ovf);
  modport slave  (input start, sub, a, b, cin, output sum, cout, busy, done, ovf);
`else
  modport master (output start, sub, a, b, cin, input sum, cout, busy, done);
  modport slave  (input start, sub, a, b, cin, output sum, cout, busy, done);
`endif
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flop, LSB first over WIDTH cycles.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output (bus.ovf).
module serial_adder #(
  parameter int WIDTH = 8
) (
  input logic          clk,
  input logic          rst,
  serial_adder_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, sum_q;
  logic [CW-1:0]    cnt;
  logic             carry, cout_q;
  logic             accept, last, s_bit, c_next;

  assign accept = bus.start && (state != RUN);
  assign last   = (state == RUN) && (cnt == CW'(WIDTH - 1));
  assign s_bit  = a_sr[0] ^ b_sr[0] ^ carry;
  assign c_next = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: next state defaults to the current state first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    state_nxt = bus.start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Subtraction is a + ~b + 1: invert B on load and force the initial carry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_q  <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
    end else if (accept) begin
      a_sr  <= bus.a;
      b_sr  <= bus.sub ? ~bus.b : bus.b;
      carry <= bus.sub | bus.cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      sum_q <= {s_bit, sum_q[WIDTH-1:1]};
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      carry <= c_next;
      cnt   <= last ? '0 : cnt + 1'b1;
      if (last) cout_q <= c_next;
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  // On the MSB step the carry flop holds the carry into the MSB.
  logic ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       ovf_q <= 1'b0;
    else if (last) ovf_q <= carry ^ c_next;
  end

  assign bus.ovf = ovf_q;
`endif

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH 8, 2 and 33 against an arithmetic reference model.
// Build with SERIAL_ADDER_OVF_EN defined to also check the overflow output.
module tb_serial_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] a_d = '0;
  logic [63:0] b_d = '0;
  logic        sub_d = 1'b0;
  logic        cin_d = 1'b0;
  logic [2:0]  start_d = '0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8))  i8  ();
  serial_adder_if #(.WIDTH(2))  i2  ();
  serial_adder_if #(.WIDTH(33)) i33 ();

  assign i8.start  = start_d[0];
  assign i2.start  = start_d[1];
  assign i33.start = start_d[2];
  assign i8.a  = a_d[7:0];
  assign i2.a  = a_d[1:0];
  assign i33.a = a_d[32:0];
  assign i8.b  = b_d[7:0];
  assign i2.b  = b_d[1:0];
  assign i33.b = b_d[32:0];
  assign i8.sub  = sub_d;
  assign i2.sub  = sub_d;
  assign i33.sub = sub_d;
  assign i8.cin  = cin_d;
  assign i2.cin  = cin_d;
  assign i33.cin = cin_d;

  serial_adder #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(i8.slave));
  serial_adder #(.WIDTH(2))  u2  (.clk(clk), .rst(rst), .bus(i2.slave));
  serial_adder #(.WIDTH(33)) u33 (.clk(clk), .rst(rst), .bus(i33.slave));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sample(input int sel, output logic [63:0] s, output logic co,
                        output logic bsy, output logic dn, output logic ov);
    ov = 1'b0;
    case (sel)
      0: begin
        s = 64'(i8.sum); co = i8.cout; bsy = i8.busy; dn = i8.done;
`ifdef SERIAL_ADDER_OVF_EN
        ov = i8.ovf;
`endif
      end
      1: begin
        s = 64'(i2.sum); co = i2.cout; bsy = i2.busy; dn = i2.done;
`ifdef SERIAL_ADDER_OVF_EN
        ov = i2.ovf;
`endif
      end
      default: begin
        s = 64'(i33.sum); co = i33.cout; bsy = i33.busy; dn = i33.done;
`ifdef SERIAL_ADDER_OVF_EN
        ov = i33.ovf;
`endif
      end
    endcase
  endtask

  function automatic logic [63:0] mask_w(input int w);
    return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  // Reference result {cout, sum} from plain integer arithmetic.
  function automatic logic [64:0] ref_result(input int w, input logic [63:0] a, input logic [63:0] b,
                                             input logic cin, input logic sub);
    logic [64:0] full;
    logic [63:0] am, bm;
    am = a & mask_w(w);
    bm = b & mask_w(w);
    if (sub) return {1'b0, (am >= bm), 63'd0} | 65'((am - bm) & mask_w(w)) | (65'(am >= bm) << w);
    full = {1'b0, am} + {1'b0, bm} + 65'(cin);
    return full & ((65'd1 << (w + 1)) - 65'd1);
  endfunction

`ifdef SERIAL_ADDER_OVF_EN
  // Signed overflow: the true signed result falls outside the w-bit range.
  function automatic logic ref_ovf(input int w, input logic [63:0] a, input logic [63:0] b,
                                   input logic cin, input logic sub);
    longint sa, sb, r, lim;
    sa  = $signed(a << (64 - w)) >>> (64 - w);
    sb  = $signed(b << (64 - w)) >>> (64 - w);
    r   = sub ? sa - sb : sa + sb + longint'(cin);
    lim = 64'sd1 <<< (w - 1);
    return (r >= lim) || (r < -lim);
  endfunction
`endif

  // One full operation on DUT sel; checks busy width, done pulse, result and hold.
  task automatic run_op(input int sel, input int w, input logic [63:0] a, input logic [63:0] b,
                        input logic cin, input logic sub, input string tag);
    logic [64:0] exp;
    logic [63:0] s;
    logic        co, bsy, dn, ov;
    int          n;
    exp = ref_result(w, a, b, cin, sub);
    @(negedge clk);
    a_d = a; b_d = b; cin_d = cin; sub_d = sub;
    start_d[sel] = 1'b1;
    @(negedge clk);
    start_d = '0;
    a_d = '0; b_d = '0; cin_d = 1'b0; sub_d = 1'b0;
    n = 0;
    sample(sel, s, co, bsy, dn, ov);
    while (bsy && n < w + 5) begin
      n++;
      @(negedge clk);
      sample(sel, s, co, bsy, dn, ov);
    end
    check({tag, " busy_cycles"}, 64'(n), 64'(w));
    check({tag, " done"}, 64'(dn), 64'd1);
    check({tag, " sum"}, s, exp[63:0] & mask_w(w));
    check({tag, " cout"}, 64'(co), 64'(exp[w]));
`ifdef SERIAL_ADDER_OVF_EN
    check({tag, " ovf"}, 64'(ov), 64'(ref_ovf(w, a & mask_w(w), b & mask_w(w), cin, sub)));
`endif
    @(negedge clk);
    sample(sel, s, co, bsy, dn, ov);
    check({tag, " done_pulse_end"}, 64'(dn), 64'd0);
    check({tag, " sum_hold"}, s, exp[63:0] & mask_w(w));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] s;
    logic        co, bsy, dn, ov;
    logic [64:0] q_exp[$];
    logic [64:0] e;
    int          t;
    logic        seen_done;

    // Reset state.
    #12;
    sample(0, s, co, bsy, dn, ov);
    check("reset sum", s, 64'd0);
    check("reset cout", 64'(co), 64'd0);
    check("reset busy", 64'(bsy), 64'd0);
    check("reset done", 64'(dn), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed WIDTH=8 cases.
    run_op(0, 8, 64'h5A, 64'h3C, 1'b0, 1'b0, "add_5a_3c");
    run_op(0, 8, 64'hFF, 64'h00, 1'b1, 1'b0, "add_ff_00_cin");
    run_op(0, 8, 64'h7F, 64'h01, 1'b0, 1'b0, "add_7f_01");
    run_op(0, 8, 64'h10, 64'h20, 1'b1, 1'b1, "sub_10_20");
    run_op(0, 8, 64'h20, 64'h10, 1'b0, 1'b1, "sub_20_10");
    run_op(0, 8, 64'h80, 64'h80, 1'b0, 1'b1, "sub_80_80");

    // Idle hold: sum and cout keep the last result.
    repeat (3) @(negedge clk);
    sample(0, s, co, bsy, dn, ov);
    check("idle_hold sum", s, 64'h00);
    check("idle_hold cout", 64'(co), 64'd1);

    // Start held high with operands changing each cycle. Timeline model: t counts
    // cycles since the accepting edge; WIDTH busy cycles, then one done cycle.
    t = 0;
    for (int i = 0; i < 40; i++) begin
      sample(0, s, co, bsy, dn, ov);
      check("b2b busy", 64'(bsy), 64'((t >= 1) && (t <= 8)));
      check("b2b done", 64'(dn), 64'(t == 9));
      if (t == 9 && q_exp.size() > 0) begin
        e = q_exp.pop_front();
        check("b2b sum", s, 64'(e[7:0]));
        check("b2b cout", 64'(co), 64'(e[8]));
      end
      if (i < 20) begin
        start_d[0] = 1'b1;
        a_d = 64'($urandom_range(255));
        b_d = 64'($urandom_range(255));
        cin_d = 1'($urandom_range(1));
        sub_d = 1'($urandom_range(1));
      end else begin
        start_d = '0;
      end
      if (start_d[0] && (t == 0 || t == 9)) begin
        q_exp.push_back(ref_result(8, a_d, b_d, cin_d, sub_d));
        t = 1;
      end else if (t == 9) begin
        t = 0;
      end else if (t > 0) begin
        t++;
      end
      @(negedge clk);
    end
    start_d = '0;
    check("b2b all_results_seen", 64'(q_exp.size()), 64'd0);

    // Asynchronous reset in the middle of an operation.
    a_d = 64'hAA; b_d = 64'h55; cin_d = 1'b0; sub_d = 1'b0;
    start_d[0] = 1'b1;
    @(negedge clk);
    start_d = '0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    sample(0, s, co, bsy, dn, ov);
    check("midrst sum", s, 64'd0);
    check("midrst cout", 64'(co), 64'd0);
    check("midrst busy", 64'(bsy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      sample(0, s, co, bsy, dn, ov);
      if (dn || bsy) seen_done = 1'b1;
    end
    check("midrst no_done_after", 64'(seen_done), 64'd0);
    run_op(0, 8, 64'h01, 64'h01, 1'b0, 1'b0, "post_rst_01_01");

    // Width sweep with random operands.
    for (int i = 0; i < 200; i++)
      run_op(1, 2, 64'($urandom_range(3)), 64'($urandom_range(3)),
             1'($urandom_range(1)), 1'($urandom_range(1)), "w2_rand");
    for (int i = 0; i < 200; i++)
      run_op(2, 33, {$urandom, $urandom}, {$urandom, $urandom},
             1'($urandom_range(1)), 1'($urandom_range(1)), "w33_rand");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
